// File: rtl/nfc_cmd_pkg.sv
// rtl/nfc_cmd_pkg.sv - shared opcodes, target IDs, status bits and sequencer state enum
package nfc_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE, SELWAY, SETCOL, SETROW, WDATA, OPCMD, RDATA, POLL_CMD, POLL_RSP, DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    OP_PROG       = 2'b00,
    OP_CACHE_PROG = 2'b01,
    OP_READ       = 2'b10,
    OP_ERASE      = 2'b11
  } req_op_e;

  localparam logic [5:0] OPC_SELWAY = 6'b100000;
  localparam logic [5:0] OPC_SETCOL = 6'b100010;
  localparam logic [5:0] OPC_SETROW = 6'b100100;
  localparam logic [5:0] OPC_PROG   = 6'b000011;
  localparam logic [5:0] OPC_READ   = 6'b000100;
  localparam logic [5:0] OPC_ERASE  = 6'b000110;
  localparam logic [5:0] OPC_STATUS = 6'b000111;

  localparam logic [4:0] TID_NONE   = 5'b00000;
  localparam logic [4:0] TID_CACHE  = 5'b00001;
  localparam logic [4:0] TID_STATUS = 5'b00100;
  localparam logic [4:0] TID_ARRAY  = 5'b00101;

  localparam logic [2:0] STS_FAIL = 3'd0;
  localparam logic [2:0] STS_ARDY = 3'd5;
  localparam logic [2:0] STS_RDY  = 3'd6;

  // Array ops wait on ARDY; cache program and read only need the cache ready.
  function automatic logic [2:0] exit_bit(input req_op_e op);
    return (op == OP_PROG || op == OP_ERASE) ? STS_ARDY : STS_RDY;
  endfunction

endpackage

// File: rtl/nfc_host_sequencer_if.sv
// rtl/nfc_host_sequencer_if.sv - controller command payload bus
interface nfc_host_sequencer_if;
  logic [5:0]  opcode;
  logic [4:0]  target_id;
  logic [4:0]  source_id;
  logic [31:0] address;
  logic [15:0] length;

  modport master (output opcode, target_id, source_id, address, length);
  modport slave  (input  opcode, target_id, source_id, address, length);
endinterface

// File: rtl/nfc_cmd_encoder.sv
// rtl/nfc_cmd_encoder.sv - maps sequencer state and latched request to a command payload
module nfc_cmd_encoder
  import nfc_cmd_pkg::*;
(
  input  seq_state_e            state_i,
  input  req_op_e               op_i,
  input  logic [7:0]            way_i,
  input  logic [15:0]           col_i,
  input  logic [23:0]           row_i,
  input  logic [15:0]           len_i,
  nfc_host_sequencer_if.master  cmd
);

  always_comb begin
    cmd.opcode    = '0;
    cmd.target_id = TID_NONE;
    cmd.source_id = '0;
    cmd.address   = '0;
    cmd.length    = '0;
    case (state_i)
      SELWAY: begin
        cmd.opcode  = OPC_SELWAY;
        cmd.address = {24'd0, way_i};
      end
      SETCOL: begin
        cmd.opcode  = OPC_SETCOL;
        cmd.address = {16'd0, col_i};
      end
      SETROW: begin
        cmd.opcode  = OPC_SETROW;
        cmd.address = {8'd0, row_i};
      end
      OPCMD: begin
        case (op_i)
          OP_READ: begin
            cmd.opcode    = OPC_READ;
            cmd.target_id = TID_ARRAY;
            cmd.length    = len_i;
          end
          OP_ERASE: begin
            cmd.opcode    = OPC_ERASE;
            cmd.target_id = TID_ARRAY;
          end
          default: begin
            cmd.opcode    = OPC_PROG;
            cmd.target_id = (op_i == OP_CACHE_PROG) ? TID_CACHE : TID_NONE;
            cmd.length    = len_i;
          end
        endcase
      end
      POLL_CMD: begin
        cmd.opcode    = OPC_STATUS;
        cmd.target_id = TID_STATUS;
        cmd.length    = 16'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nfc_host_sequencer.sv
// rtl/nfc_host_sequencer.sv - host request to NAND controller command/data sequencer
module nfc_host_sequencer
  import nfc_cmd_pkg::*;
#(
  parameter int NumberOfWays = 2,
  parameter int PollLimit    = 1024
) (
  input  logic        iSystemClock,
  input  logic        iReset,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic [1:0]  iReqOp,
  input  logic [7:0]  iReqWay,
  input  logic [15:0] iReqCol,
  input  logic [23:0] iReqRow,
  input  logic [15:0] iReqLength,
  input  logic [15:0] iHostWData,
  input  logic        iHostWValid,
  input  logic        iHostWLast,
  output logic        oHostWReady,
  output logic [15:0] oHostRData,
  output logic        oHostRValid,
  output logic        oHostRLast,
  input  logic        iHostRReady,
  output logic        oDoneValid,
  output logic [7:0]  oDoneStatus,
  output logic [1:0]  oDoneError,
  output logic [5:0]  oOpcode,
  output logic [4:0]  oTargetID,
  output logic [4:0]  oSourceID,
  output logic [31:0] oAddress,
  output logic [15:0] oLength,
  output logic        oCMDValid,
  input  logic        iCMDReady,
  output logic [15:0] oWriteData,
  output logic        oWriteLast,
  output logic        oWriteValid,
  output logic [1:0]  oWriteKeep,
  input  logic        iWriteReady,
  input  logic [15:0] iReadData,
  input  logic        iReadLast,
  input  logic        iReadValid,
  input  logic [1:0]  iReadKeep,
  output logic        oReadReady
);

  localparam int PW = $clog2(PollLimit + 1);

  seq_state_e     state_q, state_d;
  req_op_e        op_q, op_d;
  logic [7:0]     way_q, way_d;
  logic [15:0]    col_q, col_d;
  logic [23:0]    row_q, row_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    beat_q, beat_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic [7:0]     status_q, status_d;
  logic [1:0]     err_q, err_d;
  logic           cmd_hs;
  logic [7:0]     rsp;
  logic           unused_inputs;

  nfc_host_sequencer_if cmd_bus ();

  nfc_cmd_encoder u_encoder (
    .state_i (state_q),
    .op_i    (op_q),
    .way_i   (way_q),
    .col_i   (col_q),
    .row_i   (row_q),
    .len_i   (len_q),
    .cmd     (cmd_bus)
  );

  assign oOpcode    = cmd_bus.opcode;
  assign oTargetID  = cmd_bus.target_id;
  assign oSourceID  = cmd_bus.source_id;
  assign oAddress   = cmd_bus.address;
  assign oLength    = cmd_bus.length;
  assign oCMDValid  = state_q inside {SELWAY, SETCOL, SETROW, OPCMD, POLL_CMD};
  assign cmd_hs     = oCMDValid && iCMDReady;
  assign oWriteData = iHostWData;
  assign oWriteKeep = 2'b11;
  assign oHostRData = iReadData;
  assign oDoneStatus = status_q;
  assign oDoneError  = err_q;
  assign rsp         = iReadData[7:0];
  // Host last is ignored: the beat counter alone decides the final write beat.
  assign unused_inputs = ^{iHostWLast, iReadKeep};

  always_comb begin
    state_d = state_q;
    op_d = op_q; way_d = way_q; col_d = col_q; row_d = row_q; len_d = len_q;
    beat_d = beat_q; poll_d = poll_q; status_d = status_q; err_d = err_q;
    oReqReady = 1'b0; oDoneValid = 1'b0; oReadReady = 1'b1;
    oWriteValid = 1'b0; oWriteLast = 1'b0; oHostWReady = 1'b0;
    oHostRValid = 1'b0; oHostRLast = 1'b0;
    case (state_q)
      IDLE: begin
        oReqReady = 1'b1;
        if (iReqValid) begin
          op_d = req_op_e'(iReqOp); way_d = iReqWay; col_d = iReqCol;
          row_d = iReqRow; len_d = iReqLength; beat_d = '0; poll_d = '0;
          if (32'(iReqWay) >= NumberOfWays) begin
            state_d = DONE; status_d = '0; err_d = 2'b10;
          end else begin
            state_d = SELWAY;
          end
        end
      end
      SELWAY: if (cmd_hs) state_d = (op_q == OP_ERASE) ? SETROW : SETCOL;
      SETCOL: if (cmd_hs) state_d = SETROW;
      SETROW: if (cmd_hs) state_d = (op_q inside {OP_PROG, OP_CACHE_PROG}) ? WDATA : OPCMD;
      WDATA: begin
        oWriteValid = iHostWValid;
        oHostWReady = iWriteReady;
        oWriteLast  = (beat_q == len_q - 16'd1);
        if (iHostWValid && iWriteReady) begin
          beat_d = beat_q + 16'd1;
          if (oWriteLast) state_d = OPCMD;
        end
      end
      OPCMD: if (cmd_hs) state_d = (op_q == OP_READ) ? RDATA : POLL_CMD;
      RDATA: begin
        oReadReady  = iHostRReady;
        oHostRValid = iReadValid;
        oHostRLast  = iReadLast;
        if (iReadValid && iHostRReady && iReadLast) state_d = POLL_CMD;
      end
      POLL_CMD: if (cmd_hs) state_d = POLL_RSP;
      POLL_RSP: begin
        if (iReadValid) begin
          status_d = rsp;
          if (rsp[exit_bit(op_q)]) begin
            state_d = DONE; err_d = {1'b0, rsp[STS_FAIL]};
          end else if (poll_q == PW'(PollLimit - 1)) begin
            state_d = DONE; err_d = 2'b10;
          end else begin
            poll_d = poll_q + PW'(1); state_d = POLL_CMD;
          end
        end
      end
      DONE: begin
        oDoneValid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE; op_q <= OP_PROG; way_q <= '0; col_q <= '0; row_q <= '0;
      len_q <= '0; beat_q <= '0; poll_q <= '0; status_q <= '0; err_q <= '0;
    end else begin
      state_q <= state_d; op_q <= op_d; way_q <= way_d; col_q <= col_d; row_q <= row_d;
      len_q <= len_d; beat_q <= beat_d; poll_q <= poll_d; status_q <= status_d; err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_nfc_host_sequencer.sv
// tb/tb_nfc_host_sequencer.sv - scoreboard bench for nfc_host_sequencer
module tb_nfc_host_sequencer;

  logic        iSystemClock = 1'b0;
  logic        iReset;
  logic        iReqValid, oReqReady;
  logic [1:0]  iReqOp;
  logic [7:0]  iReqWay;
  logic [15:0] iReqCol, iReqLength;
  logic [23:0] iReqRow;
  logic [15:0] iHostWData, oHostRData;
  logic        iHostWValid, iHostWLast, oHostWReady;
  logic        oHostRValid, oHostRLast, iHostRReady;
  logic        oDoneValid;
  logic [7:0]  oDoneStatus;
  logic [1:0]  oDoneError;
  logic [5:0]  oOpcode;
  logic [4:0]  oTargetID, oSourceID;
  logic [31:0] oAddress;
  logic [15:0] oLength;
  logic        oCMDValid, iCMDReady;
  logic [15:0] oWriteData, iReadData;
  logic        oWriteLast, oWriteValid, iWriteReady;
  logic [1:0]  oWriteKeep, iReadKeep;
  logic        iReadLast, iReadValid, oReadReady;

  int vec = 0;
  int errs = 0;

  logic [63:0] exp_cmd[$], obs_cmd[$];
  logic [16:0] exp_w[$], obs_w[$], hw_src[$];
  logic [16:0] exp_hr[$], obs_hr[$], rd_pend[$], rd_src[$];
  logic [7:0]  sts_pend[$];
  logic [9:0]  exp_done[$], obs_done[$];

  always #5 iSystemClock = ~iSystemClock;

  nfc_host_sequencer_if cmd_mon ();
  assign cmd_mon.opcode    = oOpcode;
  assign cmd_mon.target_id = oTargetID;
  assign cmd_mon.source_id = oSourceID;
  assign cmd_mon.address   = oAddress;
  assign cmd_mon.length    = oLength;

  nfc_host_sequencer #(.NumberOfWays(2), .PollLimit(4)) dut (
    .iSystemClock(iSystemClock), .iReset(iReset),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqOp(iReqOp), .iReqWay(iReqWay),
    .iReqCol(iReqCol), .iReqRow(iReqRow), .iReqLength(iReqLength),
    .iHostWData(iHostWData), .iHostWValid(iHostWValid), .iHostWLast(iHostWLast),
    .oHostWReady(oHostWReady),
    .oHostRData(oHostRData), .oHostRValid(oHostRValid), .oHostRLast(oHostRLast),
    .iHostRReady(iHostRReady),
    .oDoneValid(oDoneValid), .oDoneStatus(oDoneStatus), .oDoneError(oDoneError),
    .oOpcode(oOpcode), .oTargetID(oTargetID), .oSourceID(oSourceID), .oAddress(oAddress),
    .oLength(oLength), .oCMDValid(oCMDValid), .iCMDReady(iCMDReady),
    .oWriteData(oWriteData), .oWriteLast(oWriteLast), .oWriteValid(oWriteValid),
    .oWriteKeep(oWriteKeep), .iWriteReady(iWriteReady),
    .iReadData(iReadData), .iReadLast(iReadLast), .iReadValid(iReadValid),
    .iReadKeep(iReadKeep), .oReadReady(oReadReady)
  );

  function automatic logic [63:0] mk_cmd(input logic [5:0] opc, input logic [4:0] tid,
                                         input logic [31:0] addr, input logic [15:0] len);
    return {opc, tid, 5'd0, addr, len};
  endfunction

  // Controller and host model: drive on the falling edge, record handshakes 2ns later.
  initial begin : ctrl_model
    forever begin
      @(negedge iSystemClock);
      iCMDReady   = ($urandom_range(0, 3) != 0);
      iWriteReady = ($urandom_range(0, 3) != 0);
      iHostRReady = ($urandom_range(0, 1) == 1);
      iHostWValid = (hw_src.size() != 0) && ($urandom_range(0, 3) != 0);
      if (hw_src.size() != 0) {iHostWLast, iHostWData} = hw_src[0];
      iReadValid = (rd_src.size() != 0);
      if (rd_src.size() != 0) {iReadLast, iReadData} = rd_src[0];
      #2;
      if (oCMDValid && iCMDReady) begin
        obs_cmd.push_back({cmd_mon.opcode, cmd_mon.target_id, cmd_mon.source_id,
                           cmd_mon.address, cmd_mon.length});
        if (oOpcode == 6'b000111) begin
          if (sts_pend.size() != 0) rd_src.push_back({1'b1, 8'hA5, sts_pend.pop_front()});
          else rd_src.push_back({1'b1, 8'hA5, 8'h00});
        end
        if (oOpcode == 6'b000100)
          while (rd_pend.size() != 0) rd_src.push_back(rd_pend.pop_front());
      end
      if (iReadValid && oReadReady) rd_src.delete(0);
      if (oHostRValid && iHostRReady) obs_hr.push_back({oHostRLast, oHostRData});
      if (oWriteValid && iWriteReady) obs_w.push_back({oWriteLast, oWriteData});
      if (iHostWValid && oHostWReady) hw_src.delete(0);
      if (oDoneValid) obs_done.push_back({oDoneStatus, oDoneError});
    end
  end

  task automatic send_req(input logic [1:0] op, input logic [7:0] way, input logic [15:0] col,
                          input logic [23:0] row, input logic [15:0] len, output bit ok);
    int n;
    @(negedge iSystemClock);
    iReqOp = op; iReqWay = way; iReqCol = col; iReqRow = row; iReqLength = len;
    iReqValid = 1'b1;
    #1;
    n = 0;
    while (!oReqReady && n < 50) begin
      @(negedge iSystemClock); #1; n++;
    end
    ok = oReqReady;
    @(negedge iSystemClock);
    iReqValid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (obs_done.size() == 0 && n < 1000) begin
      @(negedge iSystemClock); #3; n++;
    end
    ok = (obs_done.size() != 0);
    repeat (2) @(negedge iSystemClock);
    #3;
  endtask

  task automatic test_reset();
    vec++;
    if ({oReqReady, oCMDValid, oWriteValid, oWriteLast, oHostWReady, oHostRValid, oHostRLast,
         oDoneValid, oReadReady} !== 9'b1_0000_0001) begin
      errs++;
      $display("FAIL reset_ctrl: got %b required 100000001", {oReqReady, oCMDValid, oWriteValid,
               oWriteLast, oHostWReady, oHostRValid, oHostRLast, oDoneValid, oReadReady});
    end
    vec++;
    if ({oDoneStatus, oDoneError} !== 10'd0) begin
      errs++; $display("FAIL reset_done: got %h required 000", {oDoneStatus, oDoneError});
    end
    vec++;
    if (oSourceID !== 5'd0) begin
      errs++; $display("FAIL reset_srcid: got %h required 00", oSourceID);
    end
  endtask

  task automatic test_program();
    bit ok;
    logic [63:0] c, oc;
    logic [16:0] w, ow;
    logic [9:0]  d, od;
    exp_cmd.push_back(mk_cmd(6'b100000, 5'b00000, 32'h0000_0001, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b100010, 5'b00000, 32'h0000_0010, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b100100, 5'b00000, 32'h0000_0003, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b000011, 5'b00000, 32'h0, 16'd4));
    exp_cmd.push_back(mk_cmd(6'b000111, 5'b00100, 32'h0, 16'd1));
    hw_src.push_back({1'b0, 16'h0102}); hw_src.push_back({1'b1, 16'h0304});
    hw_src.push_back({1'b0, 16'h0506}); hw_src.push_back({1'b0, 16'h0708});
    exp_w.push_back({1'b0, 16'h0102}); exp_w.push_back({1'b0, 16'h0304});
    exp_w.push_back({1'b0, 16'h0506}); exp_w.push_back({1'b1, 16'h0708});
    sts_pend.push_back(8'h60);
    exp_done.push_back({8'h60, 2'b00});
    send_req(2'b00, 8'd1, 16'h0010, 24'h000003, 16'd4, ok);
    vec++; if (!ok) begin errs++; $display("FAIL prog_req: accepted %0d required 1", ok); end
    wait_done(ok);
    vec++; if (!ok) begin errs++; $display("FAIL prog_done_timeout: seen %0d required 1", ok); end
    while (exp_cmd.size() != 0) begin
      c = exp_cmd.pop_front(); oc = 'x;
      if (obs_cmd.size() != 0) oc = obs_cmd.pop_front();
      vec++; if (oc !== c) begin errs++; $display("FAIL prog_cmd: got %h required %h", oc, c); end
    end
    while (exp_w.size() != 0) begin
      w = exp_w.pop_front(); ow = 'x;
      if (obs_w.size() != 0) ow = obs_w.pop_front();
      vec++; if (ow !== w) begin errs++; $display("FAIL prog_wbeat: got %h required %h", ow, w); end
    end
    d = exp_done.pop_front(); od = 'x;
    if (obs_done.size() != 0) od = obs_done.pop_front();
    vec++; if (od !== d) begin errs++; $display("FAIL prog_done: got %h required %h", od, d); end
    vec++;
    if (obs_cmd.size() + obs_w.size() != 0) begin
      errs++; $display("FAIL prog_extra: got %0d extra required 0", obs_cmd.size() + obs_w.size());
    end
  endtask

  task automatic test_cache_program();
    bit ok;
    logic [63:0] c, oc;
    logic [9:0]  d, od;
    exp_cmd.push_back(mk_cmd(6'b100000, 5'b00000, 32'h0, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b100010, 5'b00000, 32'h0000_0040, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b100100, 5'b00000, 32'h0000_0100, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b000011, 5'b00001, 32'h0, 16'd2));
    repeat (3) exp_cmd.push_back(mk_cmd(6'b000111, 5'b00100, 32'h0, 16'd1));
    hw_src.push_back({1'b0, 16'hAAAA}); hw_src.push_back({1'b1, 16'hBBBB});
    sts_pend.push_back(8'h00); sts_pend.push_back(8'h20); sts_pend.push_back(8'h40);
    exp_done.push_back({8'h40, 2'b00});
    send_req(2'b01, 8'd0, 16'h0040, 24'h000100, 16'd2, ok);
    vec++; if (!ok) begin errs++; $display("FAIL cache_req: accepted %0d required 1", ok); end
    wait_done(ok);
    vec++; if (!ok) begin errs++; $display("FAIL cache_done_timeout: seen %0d required 1", ok); end
    while (exp_cmd.size() != 0) begin
      c = exp_cmd.pop_front(); oc = 'x;
      if (obs_cmd.size() != 0) oc = obs_cmd.pop_front();
      vec++; if (oc !== c) begin errs++; $display("FAIL cache_cmd: got %h required %h", oc, c); end
    end
    d = exp_done.pop_front(); od = 'x;
    if (obs_done.size() != 0) od = obs_done.pop_front();
    vec++; if (od !== d) begin errs++; $display("FAIL cache_done: got %h required %h", od, d); end
    vec++;
    if (obs_cmd.size() != 0) begin
      errs++; $display("FAIL cache_extra_cmd: got %0d required 0", obs_cmd.size());
    end
    obs_w.delete();
  endtask

  task automatic test_erase_timeout();
    bit ok;
    logic [63:0] c, oc;
    logic [9:0]  d, od;
    exp_cmd.push_back(mk_cmd(6'b100000, 5'b00000, 32'h0, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b100100, 5'b00000, 32'h0000_ABCD, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b000110, 5'b00101, 32'h0, 16'd0));
    repeat (4) begin
      exp_cmd.push_back(mk_cmd(6'b000111, 5'b00100, 32'h0, 16'd1));
      sts_pend.push_back(8'h00);
    end
    exp_done.push_back({8'h00, 2'b10});
    send_req(2'b11, 8'd0, 16'h0077, 24'h00ABCD, 16'd5, ok);
    vec++; if (!ok) begin errs++; $display("FAIL erase_req: accepted %0d required 1", ok); end
    wait_done(ok);
    vec++; if (!ok) begin errs++; $display("FAIL erase_done_timeout: seen %0d required 1", ok); end
    while (exp_cmd.size() != 0) begin
      c = exp_cmd.pop_front(); oc = 'x;
      if (obs_cmd.size() != 0) oc = obs_cmd.pop_front();
      vec++; if (oc !== c) begin errs++; $display("FAIL erase_cmd: got %h required %h", oc, c); end
    end
    d = exp_done.pop_front(); od = 'x;
    if (obs_done.size() != 0) od = obs_done.pop_front();
    vec++; if (od !== d) begin errs++; $display("FAIL erase_done: got %h required %h", od, d); end
    vec++;
    if (obs_cmd.size() != 0) begin
      errs++; $display("FAIL erase_extra_poll: got %0d required 0", obs_cmd.size());
    end
  endtask

  task automatic test_bad_way();
    bit ok;
    logic [1:0] oe;
    send_req(2'b00, 8'd5, 16'h0001, 24'h000001, 16'd1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL badway_req: accepted %0d required 1", ok); end
    #3;
    vec++;
    if (obs_done.size() !== 1) begin
      errs++; $display("FAIL badway_latency: got %0d pulses required 1", obs_done.size());
    end
    oe = 'x;
    if (obs_done.size() != 0) oe = obs_done[0][1:0];
    vec++; if (oe !== 2'b10) begin errs++; $display("FAIL badway_err: got %b required 10", oe); end
    repeat (3) @(negedge iSystemClock);
    #3;
    vec++;
    if (obs_cmd.size() !== 0) begin
      errs++; $display("FAIL badway_cmd: got %0d commands required 0", obs_cmd.size());
    end
    obs_done.delete();
  endtask

  task automatic test_page_read();
    bit ok;
    logic [63:0] c, oc;
    logic [16:0] r, orr;
    logic [9:0]  d, od;
    exp_cmd.push_back(mk_cmd(6'b100000, 5'b00000, 32'h0000_0001, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b100010, 5'b00000, 32'h0000_0200, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b100100, 5'b00000, 32'h0000_1234, 16'd0));
    exp_cmd.push_back(mk_cmd(6'b000100, 5'b00101, 32'h0, 16'd8));
    exp_cmd.push_back(mk_cmd(6'b000111, 5'b00100, 32'h0, 16'd1));
    for (int i = 0; i < 8; i++) begin
      rd_pend.push_back({i == 7, 16'h1000 + 16'(i) * 16'h0101});
      exp_hr.push_back({i == 7, 16'h1000 + 16'(i) * 16'h0101});
    end
    sts_pend.push_back(8'h41);
    exp_done.push_back({8'h41, 2'b01});
    send_req(2'b10, 8'd1, 16'h0200, 24'h001234, 16'd8, ok);
    vec++; if (!ok) begin errs++; $display("FAIL read_req: accepted %0d required 1", ok); end
    wait_done(ok);
    vec++; if (!ok) begin errs++; $display("FAIL read_done_timeout: seen %0d required 1", ok); end
    while (exp_cmd.size() != 0) begin
      c = exp_cmd.pop_front(); oc = 'x;
      if (obs_cmd.size() != 0) oc = obs_cmd.pop_front();
      vec++; if (oc !== c) begin errs++; $display("FAIL read_cmd: got %h required %h", oc, c); end
    end
    while (exp_hr.size() != 0) begin
      r = exp_hr.pop_front(); orr = 'x;
      if (obs_hr.size() != 0) orr = obs_hr.pop_front();
      vec++; if (orr !== r) begin errs++; $display("FAIL read_beat: got %h required %h", orr, r); end
    end
    d = exp_done.pop_front(); od = 'x;
    if (obs_done.size() != 0) od = obs_done.pop_front();
    vec++; if (od !== d) begin errs++; $display("FAIL read_done: got %h required %h", od, d); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int n;
    for (int i = 0; i < 4; i++) hw_src.push_back({1'b0, 16'h5000 + 16'(i)});
    send_req(2'b00, 8'd0, 16'h0000, 24'h000010, 16'd4, ok);
    vec++; if (!ok) begin errs++; $display("FAIL rst_req: accepted %0d required 1", ok); end
    n = 0;
    while (obs_w.size() == 0 && n < 200) begin
      @(negedge iSystemClock); #3; n++;
    end
    vec++;
    if (obs_w.size() == 0) begin errs++; $display("FAIL rst_wbeat1: got 0 beats required 1"); end
    @(negedge iSystemClock);
    #3;
    iReset = 1'b1;
    #1;
    vec++;
    if ({oReqReady, oCMDValid, oWriteValid, oWriteLast, oHostWReady, oHostRValid, oHostRLast,
         oDoneValid} !== 8'b1000_0000) begin
      errs++;
      $display("FAIL rst_mid_ctrl: got %b required 10000000", {oReqReady, oCMDValid, oWriteValid,
               oWriteLast, oHostWReady, oHostRValid, oHostRLast, oDoneValid});
    end
    vec++;
    if ({oDoneStatus, oDoneError} !== 10'd0) begin
      errs++; $display("FAIL rst_mid_done: got %h required 000", {oDoneStatus, oDoneError});
    end
    @(negedge iSystemClock);
    hw_src.delete(); rd_src.delete(); sts_pend.delete(); rd_pend.delete();
    obs_cmd.delete(); obs_w.delete(); obs_hr.delete(); obs_done.delete();
    @(negedge iSystemClock);
    iReset = 1'b0;
    #3;
    vec++;
    if (oReqReady !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b required 1", oReqReady); end
    repeat (5) @(negedge iSystemClock);
    #3;
    vec++;
    if (obs_done.size() + obs_cmd.size() != 0) begin
      errs++; $display("FAIL rst_no_pulse: got %0d events required 0", obs_done.size() + obs_cmd.size());
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    iReset = 1'b1;
    iReqValid = 1'b0; iReqOp = '0; iReqWay = '0; iReqCol = '0; iReqRow = '0; iReqLength = '0;
    iHostWData = '0; iHostWValid = 1'b0; iHostWLast = 1'b0; iHostRReady = 1'b0;
    iCMDReady = 1'b0; iWriteReady = 1'b0;
    iReadData = '0; iReadLast = 1'b0; iReadValid = 1'b0; iReadKeep = 2'b11;
    #12;
    test_reset();
    @(negedge iSystemClock);
    iReset = 1'b0;
    test_program();
    test_cache_program();
    test_erase_timeout();
    test_bad_way();
    test_page_read();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
